// File: rtl/red_pitaya_fads_pkg.sv
//------------------------------------------------------------------------------
// red_pitaya_fads_pkg : shared state encoding, register map and defaults
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package red_pitaya_fads_pkg;

  localparam int TW_DEFAULT = 24;
  localparam int CW_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUAL  = 3'd1,
    ST_DELAY = 3'd2,
    ST_FIRE  = 3'd3,
    ST_HOLD  = 3'd4
  } fads_state_e;

  localparam logic [19:0] ADDR_CTRL     = 20'h00;
  localparam logic [19:0] ADDR_MIN_W    = 20'h04;
  localparam logic [19:0] ADDR_DELAY    = 20'h08;
  localparam logic [19:0] ADDR_PULSE_W  = 20'h0C;
  localparam logic [19:0] ADDR_DEAD     = 20'h10;
  localparam logic [19:0] ADDR_DROP_CNT = 20'h14;
  localparam logic [19:0] ADDR_FIRE_CNT = 20'h18;
  localparam logic [19:0] ADDR_MISS_CNT = 20'h1C;
  localparam logic [19:0] ADDR_STATUS   = 20'h20;

endpackage

`default_nettype wire

// File: rtl/red_pitaya_fads_regs.sv
//------------------------------------------------------------------------------
// red_pitaya_fads_regs : system-bus decode, config registers and read-back
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module red_pitaya_fads_regs
  import red_pitaya_fads_pkg::*;
#(
  parameter int TW = TW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack,
  input  logic [CW-1:0] drop_cnt_i,
  input  logic [CW-1:0] fire_cnt_i,
  input  logic [CW-1:0] miss_cnt_i,
  input  logic [3:0]    status_i,
  output logic          enable_o,
  output logic          clr_o,
  output logic [TW-1:0] min_w_o,
  output logic [TW-1:0] delay_o,
  output logic [TW-1:0] pulse_w_o,
  output logic [TW-1:0] dead_o
);

  logic [19:0]   addr_w;
  logic [31:0]   rdata_w;
  logic          unused_w;
  logic          enable_q;
  logic [TW-1:0] min_w_q;
  logic [TW-1:0] delay_q;
  logic [TW-1:0] pulse_w_q;
  logic [TW-1:0] dead_q;
  logic          ack_q;
  logic [31:0]   rdata_q;

  assign addr_w   = sys_addr[19:0];
  assign unused_w = ^{sys_sel, sys_addr[31:20], sys_wdata};

  // Clear acts in the strobe cycle itself so it beats any same-cycle increment.
  assign clr_o = sys_wen && (addr_w == ADDR_CTRL) && sys_wdata[1];

  always_comb begin
    rdata_w = '0;
    case (addr_w)
      ADDR_CTRL:     rdata_w = {31'd0, enable_q};
      ADDR_MIN_W:    rdata_w = 32'(min_w_q);
      ADDR_DELAY:    rdata_w = 32'(delay_q);
      ADDR_PULSE_W:  rdata_w = 32'(pulse_w_q);
      ADDR_DEAD:     rdata_w = 32'(dead_q);
      ADDR_DROP_CNT: rdata_w = 32'(drop_cnt_i);
      ADDR_FIRE_CNT: rdata_w = 32'(fire_cnt_i);
      ADDR_MISS_CNT: rdata_w = 32'(miss_cnt_i);
      ADDR_STATUS:   rdata_w = {28'd0, status_i};
      default:       rdata_w = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q  <= 1'b0;
      min_w_q   <= '0;
      delay_q   <= '0;
      pulse_w_q <= '0;
      dead_q    <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ack_q   <= sys_wen | sys_ren;
      rdata_q <= sys_ren ? rdata_w : '0;
      if (sys_wen) begin
        case (addr_w)
          ADDR_CTRL:    enable_q  <= sys_wdata[0];
          ADDR_MIN_W:   min_w_q   <= sys_wdata[TW-1:0];
          ADDR_DELAY:   delay_q   <= sys_wdata[TW-1:0];
          ADDR_PULSE_W: pulse_w_q <= sys_wdata[TW-1:0];
          ADDR_DEAD:    dead_q    <= sys_wdata[TW-1:0];
          default:      ;
        endcase
      end
    end
  end

  assign enable_o  = enable_q;
  assign min_w_o   = min_w_q;
  assign delay_o   = delay_q;
  assign pulse_w_o = pulse_w_q;
  assign dead_o    = dead_q;
  assign sys_ack   = ack_q;
  assign sys_rdata = rdata_q;
  assign sys_err   = 1'b0;

endmodule

`default_nettype wire

// File: rtl/red_pitaya_fads_sorter.sv
//------------------------------------------------------------------------------
// red_pitaya_fads_sorter : qualify sort trigger, delay, fire ASG pulse, dead time
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module red_pitaya_fads_sorter
  import red_pitaya_fads_pkg::*;
#(
  parameter int TW = TW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic        sort_trig_i,
  output logic        asg_trig_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam logic [TW-1:0] ONE     = TW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          enable_w;
  logic          clr_w;
  logic [TW-1:0] min_w_w;
  logic [TW-1:0] delay_w;
  logic [TW-1:0] pulse_w_w;
  logic [TW-1:0] dead_w;
  logic [TW-1:0] pulse_eff_w;
  logic          rise_w;
  logic          drop_inc_w;
  logic          fire_inc_w;
  logic          miss_inc_w;

  logic          s1_q;
  logic          s1_prev_q;
  fads_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] qcnt_q, qcnt_d;
  logic          asg_q;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fire_cnt_q, fire_cnt_d;
  logic [CW-1:0] miss_cnt_q, miss_cnt_d;

  red_pitaya_fads_regs #(
    .TW (TW),
    .CW (CW)
  ) u_regs (
    .clk_i      (adc_clk_i),
    .rst_i      (adc_rst_i),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_sel    (sys_sel),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack),
    .drop_cnt_i (drop_cnt_q),
    .fire_cnt_i (fire_cnt_q),
    .miss_cnt_i (miss_cnt_q),
    .status_i   ({asg_q, state_q}),
    .enable_o   (enable_w),
    .clr_o      (clr_w),
    .min_w_o    (min_w_w),
    .delay_o    (delay_w),
    .pulse_w_o  (pulse_w_w),
    .dead_o     (dead_w)
  );

  assign rise_w      = s1_q & ~s1_prev_q;
  assign pulse_eff_w = (pulse_w_w == '0) ? ONE : pulse_w_w;

  // Timers load from the live config on state entry; running timers are untouched.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    qcnt_d     = qcnt_q;
    drop_inc_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_w) begin
          if (min_w_w <= ONE) begin
            drop_inc_w = 1'b1;
            if (delay_w == '0) begin
              state_d = ST_FIRE;
              tmr_d   = pulse_eff_w;
            end else begin
              state_d = ST_DELAY;
              tmr_d   = delay_w;
            end
          end else begin
            state_d = ST_QUAL;
            qcnt_d  = ONE;
          end
        end
      end
      ST_QUAL: begin
        if (!s1_q) begin
          state_d = ST_IDLE;
        end else if ((qcnt_q + ONE) >= min_w_w) begin
          drop_inc_w = 1'b1;
          if (delay_w == '0) begin
            state_d = ST_FIRE;
            tmr_d   = pulse_eff_w;
          end else begin
            state_d = ST_DELAY;
            tmr_d   = delay_w;
          end
        end else begin
          qcnt_d = qcnt_q + ONE;
        end
      end
      ST_DELAY: begin
        if (tmr_q <= ONE) begin
          state_d = ST_FIRE;
          tmr_d   = pulse_eff_w;
        end else begin
          tmr_d = tmr_q - ONE;
        end
      end
      ST_FIRE: begin
        if (tmr_q <= ONE) begin
          if (dead_w == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            tmr_d   = dead_w;
          end
        end else begin
          tmr_d = tmr_q - ONE;
        end
      end
      ST_HOLD: begin
        if (tmr_q <= ONE) state_d = ST_IDLE;
        else              tmr_d   = tmr_q - ONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_w) begin
      state_d    = ST_IDLE;
      drop_inc_w = 1'b0;
    end
  end

  assign fire_inc_w = (state_d == ST_FIRE) && (state_q != ST_FIRE);
  assign miss_inc_w = rise_w && ((state_q == ST_DELAY) || (state_q == ST_FIRE) ||
                                 (state_q == ST_HOLD));

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    fire_cnt_d = fire_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clr_w) begin
      drop_cnt_d = '0;
      fire_cnt_d = '0;
      miss_cnt_d = '0;
    end else begin
      if (drop_inc_w && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_ONE;
      if (fire_inc_w && (fire_cnt_q != '1)) fire_cnt_d = fire_cnt_q + CNT_ONE;
      if (miss_inc_w && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      s1_q       <= 1'b0;
      s1_prev_q  <= 1'b0;
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      qcnt_q     <= '0;
      asg_q      <= 1'b0;
      drop_cnt_q <= '0;
      fire_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      s1_q       <= sort_trig_i;
      s1_prev_q  <= s1_q;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      qcnt_q     <= qcnt_d;
      asg_q      <= (state_d == ST_FIRE);
      drop_cnt_q <= drop_cnt_d;
      fire_cnt_q <= fire_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign asg_trig_o = asg_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_red_pitaya_fads_sorter.sv
//------------------------------------------------------------------------------
// tb_red_pitaya_fads_sorter : directed self-checking bench for the FADS sorter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_red_pitaya_fads_sorter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sort_trig_i;
  logic        asg_trig_o;
  logic        busy_o;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  int n_err = 0;
  int n_chk = 0;

  red_pitaya_fads_sorter dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .sort_trig_i (sort_trig_i),
    .asg_trig_o  (asg_trig_o),
    .busy_o      (busy_o),
    .sys_addr    (sys_addr),
    .sys_wdata   (sys_wdata),
    .sys_sel     (4'hF),
    .sys_wen     (sys_wen),
    .sys_ren     (sys_ren),
    .sys_rdata   (sys_rdata),
    .sys_err     (sys_err),
    .sys_ack     (sys_ack)
  );

  always #5 clk = ~clk;

  // All sampling happens 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    tick();
    sys_wen = 1'b0;
    chk("wr_ack", 64'(sys_ack), 64'd1);
    tick();
    chk("wr_ack_drop", 64'(sys_ack), 64'd0);
    chk("wr_err", 64'(sys_err), 64'd0);
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    sys_addr = a;
    sys_ren  = 1'b1;
    tick();
    sys_ren = 1'b0;
    chk({tag, "_ack"}, 64'(sys_ack), 64'd1);
    chk(tag, 64'(sys_rdata), 64'(exp));
    chk({tag, "_err"}, 64'(sys_err), 64'd0);
    tick();
    chk({tag, "_ack_drop"}, 64'(sys_ack), 64'd0);
  endtask

  // pat[k] is the registered trigger (s1) level in relative cycle k; an optional
  // bus write is driven during cycle wr_cyc.
  task automatic run_pat(input logic [63:0] pat, input int ncyc, input int wr_cyc,
                         input logic [31:0] wa, input logic [31:0] wd,
                         output logic [63:0] asg_m, output logic [63:0] busy_m);
    asg_m       = '0;
    busy_m      = '0;
    sort_trig_i = pat[0];
    for (int k = 0; k < ncyc; k++) begin
      tick();
      asg_m[k]    = asg_trig_o;
      busy_m[k]   = busy_o;
      sort_trig_i = (k + 1 < 64) ? pat[k+1] : 1'b0;
      sys_wen     = (k == wr_cyc);
      sys_addr    = wa;
      sys_wdata   = wd;
    end
    sort_trig_i = 1'b0;
    sys_wen     = 1'b0;
    tick();
    tick();
  endtask

  task automatic cfg(input logic [31:0] mw, input logic [31:0] dl,
                     input logic [31:0] pw, input logic [31:0] dd);
    bus_wr(32'h04, mw);
    bus_wr(32'h08, dl);
    bus_wr(32'h0C, pw);
    bus_wr(32'h10, dd);
  endtask

  initial begin
    logic [63:0] am;
    logic [63:0] bm;
    rst         = 1'b1;
    sort_trig_i = 1'b0;
    sys_addr    = '0;
    sys_wdata   = '0;
    sys_wen     = 1'b0;
    sys_ren     = 1'b0;
    repeat (3) tick();
    chk("rst_asg", 64'(asg_trig_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ack", 64'(sys_ack), 64'd0);
    chk("rst_rdata", 64'(sys_rdata), 64'd0);
    chk("rst_err", 64'(sys_err), 64'd0);
    rst = 1'b0;
    tick();

    bus_rd("rst_ctrl", 32'h00, 32'h0);
    bus_rd("rst_minw", 32'h04, 32'h0);
    bus_rd("rst_status", 32'h20, 32'h0);

    bus_wr(32'h08, 32'hFFFF_FFFF);
    bus_rd("delay_mask", 32'h08, 32'h00FF_FFFF);
    bus_rd("unmapped", 32'h40, 32'h0);
    bus_wr(32'h18, 32'h1234_5678);
    bus_rd("ro_write", 32'h18, 32'h0);
    bus_wr(32'h00, 32'h3);
    bus_rd("ctrl_rb", 32'h00, 32'h1);

    // Qualified droplet: pulse in cycles 13..17, idle again at 22.
    cfg(32'd3, 32'd10, 32'd5, 32'd4);
    run_pat(64'h3F, 30, -1, 32'h0, 32'h0, am, bm);
    chk("t1_asg", am, 64'h0000_0000_0003_E000);
    chk("t1_busy", bm, 64'h0000_0000_003F_FFFE);
    bus_rd("t1_drop", 32'h14, 32'd1);
    bus_rd("t1_fire", 32'h18, 32'd1);
    bus_rd("t1_miss", 32'h1C, 32'd0);

    // Too-short trigger: drops out of QUAL, no pulse.
    bus_wr(32'h00, 32'h3);
    run_pat(64'h3, 20, -1, 32'h0, 32'h0, am, bm);
    chk("t2_asg", am, 64'h0);
    chk("t2_busy", bm, 64'h6);
    bus_rd("t2_drop", 32'h14, 32'd0);
    bus_rd("t2_fire", 32'h18, 32'd0);

    // Edge during FIRE is missed; edge after dead time fires again.
    run_pat(64'h0000_0000_0FCF_803F, 50, -1, 32'h0, 32'h0, am, bm);
    chk("t3_asg", am, 64'h0000_00F8_0003_E000);
    bus_rd("t3_drop", 32'h14, 32'd2);
    bus_rd("t3_fire", 32'h18, 32'd2);
    bus_rd("t3_miss", 32'h1C, 32'd1);

    // Zero config: single-cycle pulse one cycle after each edge.
    cfg(32'd0, 32'd0, 32'd0, 32'd0);
    run_pat(64'h249, 16, -1, 32'h0, 32'h0, am, bm);
    chk("t4_asg", am, 64'h492);
    chk("t4_busy", bm, 64'h492);
    bus_rd("t4_fire", 32'h18, 32'd6);
    bus_rd("t4_miss", 32'h1C, 32'd1);

    // Enable dropped in cycle 14 (written during 13): pulse truncated.
    cfg(32'd3, 32'd10, 32'd5, 32'd4);
    run_pat(64'h3F, 25, 13, 32'h00, 32'h0, am, bm);
    chk("t5_asg", am, 64'h6000);
    chk("t5_busy", bm, 64'h7FFE);
    bus_rd("t5_fire", 32'h18, 32'd7);
    bus_rd("t5_status", 32'h20, 32'h0);

    // Counter clear coinciding with a qualifying edge.
    bus_wr(32'h00, 32'h1);
    cfg(32'd0, 32'd0, 32'd0, 32'd0);
    run_pat(64'h1, 8, 0, 32'h00, 32'h3, am, bm);
    chk("t6_asg", am, 64'h2);
    bus_rd("t6_drop", 32'h14, 32'd0);
    bus_rd("t6_fire", 32'h18, 32'd0);
    bus_rd("t6_miss", 32'h1C, 32'd0);
    bus_rd("t6_ctrl", 32'h00, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
